// File: rtl/crpa_kix_pkg.sv
// rtl/crpa_kix_pkg.sv - shared state encoding and sizing helpers for the KIX coefficient controller
package crpa_kix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_SETTLE = 2'd2
  } kix_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Filter fill latency (taps + adder-tree depth) plus two cycles of margin.
  function automatic int settle_default(input int nt);
    return nt + clog2(nt) + 2;
  endfunction

endpackage

// File: rtl/kix_coef_bank.sv
// rtl/kix_coef_bank.sv - NT x NCFWIDTH coefficient register array with tap write port,
// full-width load port and flattened output
module kix_coef_bank #(
  parameter int NT       = 16,
  parameter int NCFWIDTH = 16,
  parameter int AW       = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   we_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic [NCFWIDTH-1:0]    wdata_i,
  input  logic                   load_i,
  input  logic [NT*NCFWIDTH-1:0] load_data_i,
  output logic [NT*NCFWIDTH-1:0] data_o
);

  for (genvar i = 0; i < NT; i++) begin : g_tap
    logic [NCFWIDTH-1:0] tap_q;

    // A bulk load wins over a tap write; the controller never issues both at once.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        tap_q <= '0;
      end else if (load_i) begin
        tap_q <= load_data_i[i*NCFWIDTH +: NCFWIDTH];
      end else if (we_i && (int'(waddr_i) == i)) begin
        tap_q <= wdata_i;
      end
    end

    assign data_o[i*NCFWIDTH +: NCFWIDTH] = tap_q;
  end

endmodule

// File: rtl/kix_coef_ctrl.sv
// rtl/kix_coef_ctrl.sv - shadow/active coefficient banks with tick-aligned swap and output blanking.
// Optional readback port enabled by KIX_COEF_READBACK_EN.
module kix_coef_ctrl
  import crpa_kix_pkg::*;
#(
  parameter int NT       = 16,
  parameter int NCFWIDTH = 16,
  parameter int SETTLE   = settle_default(NT),
  parameter int AW       = clog2(NT)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [NCFWIDTH-1:0]    wr_data,
  input  logic                   commit,
  input  logic                   tick,
  output logic [NT*NCFWIDTH-1:0] coeff_concat,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   addr_err
`ifdef KIX_COEF_READBACK_EN
  ,
  input  logic                   rd_sel,
  input  logic [AW-1:0]          rd_addr,
  output logic [NCFWIDTH-1:0]    rd_data
`endif
);

  localparam int CW = (clog2(SETTLE) < 1) ? 1 : clog2(SETTLE);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

  kix_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_ready_q, wr_ready_d;
  logic out_valid_q, out_valid_d;
  logic busy_q, busy_d;
  logic addr_err_q, addr_err_d;
  logic wr_fire, wr_in_range, shadow_we, swap;
  logic [NT*NCFWIDTH-1:0] shadow_flat, active_flat;

  assign wr_fire     = wr_valid & wr_ready_q;
  assign wr_in_range = int'(wr_addr) < NT;
  assign shadow_we   = wr_fire & wr_in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    swap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (tick) begin
          swap    = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = CNT_INIT;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state edge.
    wr_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d != ST_SETTLE);
    addr_err_d  = wr_fire & ~wr_in_range;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= CNT_INIT;
      wr_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ready_q  <= wr_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      addr_err_q  <= addr_err_d;
    end
  end

  kix_coef_bank #(
    .NT       (NT),
    .NCFWIDTH (NCFWIDTH),
    .AW       (AW)
  ) u_shadow (
    .clk         (clk),
    .resetn      (resetn),
    .we_i        (shadow_we),
    .waddr_i     (wr_addr),
    .wdata_i     (wr_data),
    .load_i      (1'b0),
    .load_data_i ('0),
    .data_o      (shadow_flat)
  );

  kix_coef_bank #(
    .NT       (NT),
    .NCFWIDTH (NCFWIDTH),
    .AW       (AW)
  ) u_active (
    .clk         (clk),
    .resetn      (resetn),
    .we_i        (1'b0),
    .waddr_i     ('0),
    .wdata_i     ('0),
    .load_i      (swap),
    .load_data_i (shadow_flat),
    .data_o      (active_flat)
  );

  assign coeff_concat = active_flat;
  assign wr_ready     = wr_ready_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign addr_err     = addr_err_q;

`ifdef KIX_COEF_READBACK_EN
  logic [NCFWIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NT; i++) begin
      if (int'(rd_addr) == i) begin
        rd_data_d = rd_sel ? shadow_flat[i*NCFWIDTH +: NCFWIDTH]
                           : active_flat[i*NCFWIDTH +: NCFWIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_kix_coef_ctrl.sv
// tb/tb_kix_coef_ctrl.sv - scoreboard bench for kix_coef_ctrl (AW widened to 5 so addr 20 is expressible)
module tb_kix_coef_ctrl;

  localparam int NT     = 16;
  localparam int W      = 16;
  localparam int SETTLE = 22;
  localparam int AW     = 5;
  localparam int NTOT   = NT * W;

  localparam int EV_COEF = 0;
  localparam int EV_FALL = 1;
  localparam int EV_RISE = 2;
  localparam int EV_AERR = 3;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr = '0;
  logic [W-1:0]    wr_data = '0;
  logic            commit = 1'b0;
  logic            tick = 1'b0;
  logic [NTOT-1:0] coeff_concat;
  logic            out_valid;
  logic            busy;
  logic            addr_err;
`ifdef KIX_COEF_READBACK_EN
  logic            rd_sel = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic [W-1:0]    rd_data;
`endif

  kix_coef_ctrl #(
    .NT       (NT),
    .NCFWIDTH (W),
    .SETTLE   (SETTLE),
    .AW       (AW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .tick         (tick),
    .coeff_concat (coeff_concat),
    .out_valid    (out_valid),
    .busy         (busy),
    .addr_err     (addr_err)
`ifdef KIX_COEF_READBACK_EN
    ,
    .rd_sel       (rd_sel),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int              kind;
    int              cyc;
    logic [NTOT-1:0] data;
  } ev_t;
  ev_t exp_q[$];

  logic [W-1:0] sh_m  [NT];
  logic [W-1:0] act_m [NT];

  function automatic logic [NTOT-1:0] model_concat();
    logic [NTOT-1:0] r;
    r = '0;
    for (int i = 0; i < NT; i++) r[i*W +: W] = act_m[i];
    return r;
  endfunction

  task automatic push_ev(input int kind, input int c, input logic [NTOT-1:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [NTOT-1:0] got, input logic [NTOT-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every observable DUT event is matched against the next expected one.
  task automatic take_ev(input int kind, input logic [NTOT-1:0] d);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: got unexpected kind=%0d at cyc=%0d data=%h", kind, cyc, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.data !== d) begin
        n_err++;
        $display("FAIL event: got kind=%0d cyc=%0d data=%h, want kind=%0d cyc=%0d data=%h",
                 kind, cyc, d, e.kind, e.cyc, e.data);
      end
    end
  endtask

  logic [NTOT-1:0] prev_c = '0;
  logic            prev_ov = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      prev_c  = coeff_concat;
      prev_ov = out_valid;
    end else begin
      if (coeff_concat !== prev_c) take_ev(EV_COEF, coeff_concat);
      if (!out_valid && prev_ov)   take_ev(EV_FALL, '0);
      if (out_valid && !prev_ov)   take_ev(EV_RISE, '0);
      if (addr_err)                take_ev(EV_AERR, '0);
      prev_c  = coeff_concat;
      prev_ov = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [W-1:0] data);
    chk("wr_ready_idle", NTOT'(wr_ready), NTOT'(1));
    wr_valid = 1'b1;
    wr_addr  = AW'(addr);
    wr_data  = data;
    if (addr < NT) sh_m[addr] = data;
    else           push_ev(EV_AERR, cyc + 1, '0);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic commit_and_swap(input int wait_cycles);
    int swap_cyc;
    logic [NTOT-1:0] old_c;
    old_c    = model_concat();
    swap_cyc = cyc + 2 + wait_cycles;
    for (int i = 0; i < NT; i++) act_m[i] = sh_m[i];
    if (model_concat() !== old_c) push_ev(EV_COEF, swap_cyc, model_concat());
    push_ev(EV_FALL, swap_cyc, '0);
    push_ev(EV_RISE, swap_cyc + SETTLE, '0);
    commit = 1'b1;
    tick   = (wait_cycles == 0);
    step();
    commit = 1'b0;
    for (int i = 0; i < wait_cycles; i++) begin
      if (i == 0 || i == wait_cycles - 1) begin
        chk("armed_wr_ready", NTOT'(wr_ready), NTOT'(0));
        chk("armed_coeff", coeff_concat, old_c);
      end
      step();
    end
    tick = 1'b1;
    step();
  endtask

  task automatic wait_settle();
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    n_vec++;
    if (!out_valid) begin
      n_err++;
      $display("FAIL settle_timeout: got out_valid=%0b want 1 within 60 cycles", out_valid);
    end
    chk("settled_wr_ready", NTOT'(wr_ready), NTOT'(1));
    chk("settled_busy", NTOT'(busy), NTOT'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NT; i++) begin
      sh_m[i]  = '0;
      act_m[i] = '0;
    end

    repeat (3) step();
    chk("rst_coeff", coeff_concat, '0);
    chk("rst_out_valid", NTOT'(out_valid), NTOT'(0));
    chk("rst_wr_ready", NTOT'(wr_ready), NTOT'(0));
    chk("rst_busy", NTOT'(busy), NTOT'(1));
    chk("rst_addr_err", NTOT'(addr_err), NTOT'(0));

    resetn = 1'b1;
    push_ev(EV_RISE, cyc + SETTLE, '0);
    step();
    chk("settling_wr_ready", NTOT'(wr_ready), NTOT'(0));
    wait_settle();

    // Full bank load 1..16, tick held high.
    tick = 1'b1;
    for (int i = 0; i < NT; i++) wr(i, W'(i + 1));
    commit_and_swap(0);
    wait_settle();
    chk("full_bank", coeff_concat, model_concat());

    // Commit with tick held low for 100 cycles.
    wr(0, 16'h8001);
    commit_and_swap(100);
    wait_settle();

    // Out-of-range write is dropped; swap leaves the banks unchanged.
    wr(20, 16'hDEAD);
    chk("oor_wr_ready", NTOT'(wr_ready), NTOT'(1));
    commit_and_swap(0);
    wait_settle();
    chk("oor_bank", coeff_concat, model_concat());

    // Partial update plus a second commit during SETTLE.
    wr(3, 16'hABCD);
    commit_and_swap(0);
    repeat (5) step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    wait_settle();
    repeat (30) step();
    chk("partial_bank", coeff_concat, model_concat());

    // Reset while ARMED aborts the swap.
    wr(5, 16'h1234);
    commit = 1'b1;
    tick   = 1'b0;
    step();
    commit = 1'b0;
    repeat (3) step();
    chk("armed_busy", NTOT'(busy), NTOT'(1));
    resetn = 1'b0;
    #1;
    chk("async_rst_coeff", coeff_concat, '0);
    chk("async_rst_out_valid", NTOT'(out_valid), NTOT'(0));
    chk("async_rst_busy", NTOT'(busy), NTOT'(1));
    for (int i = 0; i < NT; i++) begin
      sh_m[i]  = '0;
      act_m[i] = '0;
    end
    step();
    step();
    resetn = 1'b1;
    push_ev(EV_RISE, cyc + SETTLE, '0);
    tick = 1'b1;
    wait_settle();
    repeat (5) step();
    chk("post_rst_coeff", coeff_concat, '0);
`ifdef KIX_COEF_READBACK_EN
    rd_sel  = 1'b1;
    rd_addr = AW'(5);
    step();
    chk("rd_shadow", NTOT'(rd_data), '0);
    rd_sel  = 1'b0;
    rd_addr = AW'(0);
    step();
    chk("rd_active", NTOT'(rd_data), '0);
`endif

    repeat (5) step();
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_event: got none, want kind=%0d cyc=%0d", e.kind, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
